g_shr_seq: RTL and testbench

- Multi-cycle 32-bit right shifter for the gate-level ALU32 datapath. It is the right-direction counterpart of the existing left-shift stages.
- Accepts an operand, a 5-bit shift amount and a logical/arithmetic select.
- Shifts right by 2 per clock, with a final shift by 1 when the remaining amount is odd.
- Result is presented with a one-cycle Done pulse, so the ALU sequencer can time-share one small shift stage instead of a full barrel shifter.

---
 rtl/g_alu_pkg.sv | 33 +++
 rtl/g_shr2_stage.sv | 52 +++++
 rtl/g_shr_seq.sv | 132 +++++++++++++
 tb/tb_g_shr_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/g_alu_pkg.sv
// ---------------------------------------------------------------------------
// g_alu_pkg
// Shared constants and types for the gate-level ALU32 shift datapath.
//   G_WIDTH / G_SHW : operand width and shift-amount width (2**G_SHW == G_WIDTH)
//   state_t         : sequencer state encoding (S_IDLE, S_SHIFT, S_DONE)
//   STEP_*          : step codes understood by g_shr2_stage
// ---------------------------------------------------------------------------
package g_alu_pkg;

  localparam int G_WIDTH = 32;
  localparam int G_SHW   = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] STEP_0 = 2'd0;
  localparam logic [1:0] STEP_1 = 2'd1;
  localparam logic [1:0] STEP_2 = 2'd2;

  // Size of the next shift step for a given remaining amount: 2 while at
  // least two positions remain, then a final single step for odd amounts.
  function automatic logic [1:0] step_for(input logic [G_SHW-1:0] rem);
    logic [1:0] s;
    if (rem >= G_SHW'(2))      s = STEP_2;
    else if (rem == G_SHW'(1)) s = STEP_1;
    else                       s = STEP_0;
    return s;
  endfunction

endpackage

// File: rtl/g_shr2_stage.sv
// ---------------------------------------------------------------------------
// g_shr2_stage
// Combinational right-shift stage: shifts data right by 0, 1 or 2 positions
// and inserts fill_bits at the top. Right-direction twin of the G_Shi2 stage.
//   data      [WIDTH-1:0] in  : value to shift
//   fill_bits [1:0]       in  : bits entering at the MSB end. For a 1-step
//                               shift only fill_bits[0] is used. For a
//                               rotate, pass data[1:0] here.
//   step      [1:0]       in  : 0, 1 or 2 (3 behaves as 0)
//   result    [WIDTH-1:0] out : shifted value
// ---------------------------------------------------------------------------
module g_shr2_stage
  import g_alu_pkg::*;
#(
  parameter int WIDTH = G_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       fill_bits,
  input  logic [1:0]       step,
  output logic [WIDTH-1:0] result
);

  // Per-bit 3:1 mux. Bit gi receives data[gi+step], or a fill bit once that
  // source index runs past the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic src1;
      logic src2;
      if (gi + 1 < WIDTH) begin : g_s1_data
        assign src1 = data[gi+1];
      end else begin : g_s1_fill
        assign src1 = fill_bits[0];
      end
      if (gi + 2 < WIDTH) begin : g_s2_data
        assign src2 = data[gi+2];
      end else begin : g_s2_fill
        // top two bits: result[WIDTH-2] <- fill_bits[0], result[WIDTH-1] <- fill_bits[1]
        assign src2 = fill_bits[gi-(WIDTH-2)];
      end
      always_comb begin
        result[gi] = data[gi];
        case (step)
          STEP_1:  result[gi] = src1;
          STEP_2:  result[gi] = src2;
          default: result[gi] = data[gi];
        endcase
      end
    end
  endgenerate

endmodule

// File: rtl/g_shr_seq.sv
// ---------------------------------------------------------------------------
// g_shr_seq
// Multi-cycle right shifter. It shifts by 2 per clock, with a final 1-bit
// step for odd amounts, and pulses Done for one cycle when Out is valid.
// Optional macro G_SHR_ROTATE_EN adds the Rot input. Rot=1 selects rotate
// right and ignores Arith.
//   clk    in            : clock, rising edge
//   rst_n  in            : asynchronous active-low reset
//   Start  in            : request, honoured in IDLE or DONE only
//   In     in  [WIDTH-1:0] operand
//   Amt    in  [SHW-1:0]  shift amount
//   Arith  in            : 1 = sign fill, 0 = zero fill
//   Rot    in            : (G_SHR_ROTATE_EN only) 1 = rotate right
//   Busy   out           : high in SHIFT
//   Done   out           : one-cycle pulse, Out valid
//   Out    out [WIDTH-1:0] result, held until the next accepted Start
// ---------------------------------------------------------------------------
module g_shr_seq
  import g_alu_pkg::*;
#(
  parameter int WIDTH = G_WIDTH,
  parameter int SHW   = G_SHW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] In,
  input  logic [SHW-1:0]   Amt,
  input  logic             Arith,
`ifdef G_SHR_ROTATE_EN
  input  logic             Rot,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Out
);

  state_t           state_reg;
  logic [WIDTH-1:0] out_reg;
  logic [SHW-1:0]   rem_reg;
  logic             fill_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             rot_reg;

  logic             rot_in;
  logic [1:0]       step;
  logic [1:0]       fill_bits;
  logic [SHW-1:0]   rem_next;
  logic [WIDTH-1:0] shifted;

`ifdef G_SHR_ROTATE_EN
  assign rot_in = Rot;
`else
  assign rot_in = 1'b0;
`endif

  // Step sizing is derived from the remaining count alone. The step value is
  // 0, 1 or 2, so widening it to SHW bits is lossless.
  assign step     = step_for(G_SHW'(rem_reg));
  assign rem_next = rem_reg - {{(SHW-2){1'b0}}, step};

  // A rotate feeds the bits leaving at bit 0 back in at the top. A plain
  // shift inserts the fill bit captured at Start.
  assign fill_bits = rot_reg ? out_reg[1:0] : {fill_reg, fill_reg};

  g_shr2_stage #(.WIDTH(WIDTH)) u_stage (
    .data      (out_reg),
    .fill_bits (fill_bits),
    .step      (step),
    .result    (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      out_reg   <= '0;
      rem_reg   <= '0;
      fill_reg  <= 1'b0;
      rot_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (Start) begin
            out_reg  <= In;
            rem_reg  <= Amt;
            rot_reg  <= rot_in;
            // Sign fill is frozen here, so later changes to In cannot leak in.
            fill_reg <= Arith & In[WIDTH-1] & ~rot_in;
            if (Amt != '0) begin
              state_reg <= S_SHIFT;
              busy_reg  <= 1'b1;
              done_reg  <= 1'b0;
            end else begin
              state_reg <= S_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end else begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end
        end
        S_SHIFT: begin
          out_reg <= shifted;
          rem_reg <= rem_next;
          if (rem_next == '0) begin
            state_reg <= S_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_reg;
  assign Done = done_reg;
  assign Out  = out_reg;

endmodule

// File: tb/tb_g_shr_seq.sv
// ---------------------------------------------------------------------------
// tb_g_shr_seq
// Self-checking bench for g_shr_seq. It runs directed cases, then random
// operations, against a reference built from plain shift/rotate arithmetic.
// ---------------------------------------------------------------------------
module tb_g_shr_seq;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          Start;
  logic [W-1:0]  In;
  logic [4:0]    Amt;
  logic          Arith;
  logic          Rot;
  logic          Busy;
  logic          Done;
  logic [W-1:0]  Out;

  int checks;
  int failures;

  g_shr_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Start (Start),
    .In    (In),
    .Amt   (Amt),
    .Arith (Arith),
`ifdef G_SHR_ROTATE_EN
    .Rot   (Rot),
`endif
    .Busy  (Busy),
    .Done  (Done),
    .Out   (Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, need 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model. It applies the specification's rules directly.
  function automatic logic [31:0] ref_out(input logic [31:0] v, input int amt,
                                          input logic arith, input logic rot);
    logic [63:0] dbl;
    if (rot) begin
      dbl = {v, v} >> amt;
      return dbl[31:0];
    end
    if (arith) return $signed(v) >>> amt;
    return v >> amt;
  endfunction

  task automatic launch(input logic [31:0] v, input logic [4:0] a,
                        input logic ar, input logic rt);
    In = v; Amt = a; Arith = ar; Rot = rt; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    In = $urandom; Amt = 5'($urandom); Arith = 1'($urandom); Rot = 1'($urandom);
  endtask

  // This task is called at #1 after the accepting edge. It returns in the
  // Done-high cycle, or once the cycle budget has expired.
  task automatic wait_done(input string tag, input logic [31:0] v, input int a,
                           input logic ar, input logic rt, input bit inject);
    int lat = 1;
    int busy_n = 0;
    int excl = 0;
    while (!Done && lat < 40) begin
      if (Busy) busy_n++;
      if (Busy && Done) excl++;
      if (inject && lat == 2) begin
        Start = 1'b1; In = ~v; Amt = 5'd1; Arith = ~ar;
      end
      @(posedge clk); #1;
      Start = 1'b0;
      lat++;
    end
    if (Busy && Done) excl++;
    chk({tag, " done_seen"}, 32'(Done), 32'd1);
    chk({tag, " latency"}, lat, 1 + (a + 1) / 2);
    chk({tag, " busy_cycles"}, busy_n, (a + 1) / 2);
    chk({tag, " busy_done_excl"}, excl, 0);
    chk({tag, " out"}, Out, ref_out(v, a, ar, rt));
    $display("op %s in=0x%08h amt=%0d arith=%0d rot=%0d out=0x%08h lat=%0d",
             tag, v, a, ar, rt, Out, lat);
  endtask

  // Called in the Done cycle. It checks that the pulse ends and Out is held.
  task automatic check_hold(input string tag, input logic [31:0] exp);
    @(posedge clk); #1;
    chk({tag, " done_pulse_end"}, 32'(Done), 32'd0);
    chk({tag, " out_hold"}, Out, exp);
  endtask

  typedef struct {
    logic [31:0] v;
    int          a;
    logic        ar;
  } dir_t;

  dir_t dirs [6] = '{
    '{32'hA0104010, 4,  1'b0},
    '{32'hA0104010, 5,  1'b1},
    '{32'hA0104010, 5,  1'b0},
    '{32'h12345678, 0,  1'b0},
    '{32'h80000000, 31, 1'b1},
    '{32'h80000000, 31, 1'b0}
  };

  initial begin
    logic [31:0] v;
    logic [31:0] expv;
    int          a;
    logic        ar;
    logic        rt;
    int          bad_done;

    checks = 0; failures = 0;
    rst_n = 1'b0; Start = 1'b0; In = '0; Amt = '0; Arith = 1'b0; Rot = 1'b0;
    #12;
    chk("reset out", Out, 32'h0);
    chk("reset busy", 32'(Busy), 32'd0);
    chk("reset done", 32'(Done), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases. Every other operation is issued back-to-back.
    foreach (dirs[i]) begin
      launch(dirs[i].v, 5'(dirs[i].a), dirs[i].ar, 1'b0);
      wait_done($sformatf("dir%0d", i), dirs[i].v, dirs[i].a, dirs[i].ar, 1'b0, 1'b0);
      if (i % 2 == 1) check_hold($sformatf("dir%0d", i),
                                 ref_out(dirs[i].v, dirs[i].a, dirs[i].ar, 1'b0));
    end

    // Start during SHIFT with a different operand must be ignored.
    launch(32'hA0104010, 5'd4, 1'b0, 1'b0);
    wait_done("ignore_mid", 32'hA0104010, 4, 1'b0, 1'b0, 1'b1);
    // Start in the Done cycle runs back-to-back.
    launch(32'h000000F0, 5'd4, 1'b0, 1'b0);
    wait_done("b2b", 32'h000000F0, 4, 1'b0, 1'b0, 1'b0);
    chk("b2b value", Out, 32'h0000000F);
    check_hold("b2b", 32'h0000000F);

`ifdef G_SHR_ROTATE_EN
    launch(32'h00000001, 5'd1, 1'b0, 1'b1);
    wait_done("rot1", 32'h00000001, 1, 1'b0, 1'b1, 1'b0);
    chk("rot1 value", Out, 32'h80000000);
    check_hold("rot1", 32'h80000000);
`endif

    // Reset asserted mid-SHIFT discards the operation.
    launch(32'hDEADBEEF, 5'd31, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out", Out, 32'h0);
    chk("midrst busy", 32'(Busy), 32'd0);
    chk("midrst done", 32'(Done), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    bad_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (Done || Busy) bad_done++;
    end
    chk("midrst no_done", bad_done, 0);

    // Random operations. About a third are chained back-to-back.
    for (int k = 0; k < 40; k++) begin
      v  = $urandom;
      a  = $urandom_range(0, 31);
      ar = 1'($urandom);
`ifdef G_SHR_ROTATE_EN
      rt = 1'($urandom);
`else
      rt = 1'b0;
`endif
      launch(v, 5'(a), ar, rt);
      wait_done($sformatf("rnd%0d", k), v, a, ar, rt, ($urandom_range(0, 3) == 0));
      expv = ref_out(v, a, ar, rt);
      if ($urandom_range(0, 2) != 0) check_hold($sformatf("rnd%0d", k), expv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
